// File: rtl/ifq_fetch_if.sv
// Fetch-queue bus: branch redirect, I-cache request/response and dispatch pop.
// The slave side is the fetch queue itself.
interface ifq_fetch_if #(parameter int PC_W = 32);
    logic            jmp_branch_valid;
    logic [PC_W-1:0] jmp_branch_address;
    logic            icache_rd_en;
    logic [PC_W-1:0] icache_addr;
    logic            icache_valid;
    logic [31:0]     icache_data;
    logic            ifq_rd_en;
    logic            ifq_empty;
    logic [31:0]     ifq_dout;
    logic [PC_W-1:0] ifq_pc_out;

    modport master (
        output jmp_branch_valid, jmp_branch_address, icache_valid, icache_data, ifq_rd_en,
        input  icache_rd_en, icache_addr, ifq_empty, ifq_dout, ifq_pc_out
    );

    modport slave (
        input  jmp_branch_valid, jmp_branch_address, icache_valid, icache_data, ifq_rd_en,
        output icache_rd_en, icache_addr, ifq_empty, ifq_dout, ifq_pc_out
    );
endinterface

// File: rtl/ifq_fetch.sv
// Instruction fetch queue: one outstanding I-cache read at a time, FWFT FIFO
// towards dispatch, and a redirect that flushes everything in the same cycle.
module ifq_fetch #(
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    ifq_fetch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic [AW:0]     count, count_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            empty_q;
    logic            redirect, push, pop, rd_req;

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    assign redirect = bus.jmp_branch_valid;
    // A response landing together with a redirect belongs to the old path.
    assign push     = (state == WAIT) && bus.icache_valid && !redirect;
    assign pop      = bus.ifq_rd_en && !empty_q && !redirect;

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            FETCH: begin
                rd_req = rst_n && !redirect && (count < (AW+1)'(DEPTH));
                if (rd_req) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.icache_valid) state_nxt = FETCH;
                else if (redirect)    state_nxt = DISCARD;
            end
            DISCARD: begin
                if (bus.icache_valid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + (AW+1)'(1);
        else if (pop && !push) count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            empty_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= bus.jmp_branch_address;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                empty_q  <= 1'b1;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                    wr_ptr   <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count   <= count_nxt;
                empty_q <= (count_nxt == '0);
            end
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.icache_data;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    assign bus.icache_rd_en = rd_req;
    assign bus.icache_addr  = {fetch_pc[PC_W-1:2], 2'b00};
    assign bus.ifq_empty    = empty_q;
    assign bus.ifq_dout     = empty_q ? '0 : instr_mem[rd_ptr];
    assign bus.ifq_pc_out   = empty_q ? '0 : pc_mem[rd_ptr] + PC_W'(4);
endmodule

// File: doc/ifq_fetch.md
Name: ifq_fetch

Overview:
Instruction fetch queue: the stage directly downstream of the branch/jump address logic.
- Holds the fetch PC and issues single-word read requests to the I-cache.
- Buffers returned instructions in a small FIFO for the dispatch unit.
- On a jump/branch redirect it flushes all buffered and in-flight instructions and restarts fetch at the redirect address in the same cycle.

Parameters:
PC_W, 32, width of all PC/address values
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 0, fetch PC loaded at reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
jmp_branch_valid  input  1  redirect strobe from branch logic
jmp_branch_address  input  PC_W  redirect target
icache_rd_en  output  1  read request, one-cycle pulse
icache_addr  output  PC_W  request address (= fetch PC)
icache_valid  input  1  data for the outstanding request is valid
icache_data  input  32  returned instruction word
ifq_rd_en  input  1  dispatch pops head entry
ifq_empty  output  1  FIFO empty
ifq_dout  output  32  head instruction (first-word-fall-through)
ifq_pc_out  output  PC_W  head instruction address + 4

Behaviour:
- Reset (rst_n=0 at clk edge), applied whatever the state:
  - fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0, state=FETCH.
  - Outputs: ifq_empty=1, icache_rd_en=0, ifq_dout=0 and ifq_pc_out=0 while empty.
  - An in-flight request is forgotten; an icache_valid in the first cycle after reset is ignored.
- FIFO entry = {instr[31:0], pc[PC_W-1:0]}.
  - Head is visible combinationally.
  - ifq_pc_out = head.pc + 4, modulo 2^PC_W.
- At most one I-cache request is outstanding. State machine:
  - FETCH:
    - icache_rd_en = (count<DEPTH) && !jmp_branch_valid; icache_addr = fetch_pc with bits [1:0] forced to 0.
    - If icache_rd_en is asserted, go to WAIT.
  - WAIT:
    - icache_rd_en=0.
    - On icache_valid: push {icache_data, fetch_pc}, fetch_pc += 4 (wrap modulo 2^PC_W), go to FETCH.
    - Response latency is unbounded; the block waits indefinitely.
  - DISCARD:
    - icache_rd_en=0.
    - On icache_valid: drop the data, go to FETCH. fetch_pc is unchanged (it already holds the redirect target).
- Redirect (jmp_branch_valid=1) has highest priority after reset, in any state:
  - Flush: count=0, pointers=0, ifq_empty=1 next cycle.
  - fetch_pc = jmp_branch_address.
  - Next state by current state:
    - FETCH -> FETCH. No request is issued that cycle.
    - WAIT with icache_valid same cycle -> FETCH; the response is dropped.
    - WAIT without icache_valid -> DISCARD.
    - DISCARD with icache_valid same cycle -> FETCH.
    - DISCARD without icache_valid -> DISCARD.
  - The first request to the target is issued the cycle after the redirect, at the earliest.
  - A pop requested in the redirect cycle is ignored.
- Pop: ifq_rd_en with ifq_empty=0 advances the read pointer and decrements count. ifq_rd_en while empty is ignored, with no pointer or count change.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pop with a push into an empty FIFO is impossible, because the pop is ignored while empty.
- Full: a request is issued only when count<DEPTH, and pops only lower count, so a push never overflows.
- Pointers wrap modulo DEPTH. ifq_empty = (count==0), registered from count.

Test Plan:
1. Reset, RESET_PC=0x100, cache answers 1 cycle after each request with data=addr^0xAAAA_0000, dispatch never pops:
   - Requests go to 0x100, 0x104, 0x108, 0x10C, then icache_rd_en stays 0 (full).
   - Head dout=0xAAAA_0100, pc_out=0x104.
2. Continuing from 1, pop every cycle:
   - Outputs appear in order 0x100..0x10C, then 0x110...
   - No word is lost or duplicated; count never exceeds 4.
   - ifq_empty=1 only when the FIFO is drained.
3. Redirect in WAIT:
   - Request 0x200 outstanding; assert jmp_branch_valid with address 0x400, no icache_valid.
   - Cache returns 3 cycles later: the data is dropped.
   - The next request goes to 0x400; the FIFO holds no 0x200 entry.
4. Redirect in the same cycle as icache_valid:
   - Data is dropped, state goes to FETCH, and 0x400 is requested the next cycle.
   - A simultaneous ifq_rd_en on a non-empty FIFO is ignored and ifq_empty=1 the next cycle.
5. Pop while empty, and pop+push same cycle with count=2:
   - Empty pop: no change.
   - Pop+push: count stays 2 and the order is preserved.
6. Wrap:
   - fetch_pc=0xFFFF_FFFC: the next fetch_pc is 0x0 and pc_out=0x0.
   - rst_n low while in WAIT or DISCARD: fetch_pc=RESET_PC, ifq_empty=1, a late icache_valid is ignored, and fetch restarts at RESET_PC.
